// File: rtl/axi_lite_cfg_regfile.sv
// axi_lite_cfg_regfile: AXI4-Lite slave with NUM_RW byte-writable control words
// (word index 0..NUM_RW-1) followed by NUM_RO snapshotted status words.
// Illegal accesses (writes to status words, any access past the map) get SLVERR
// and change no state. The write and read channels are fully independent.
module axi_lite_cfg_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 9,
    parameter int NUM_RW             = 8,
    parameter int NUM_RO             = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] rw_regs,
    output logic [NUM_RW-1:0]               rw_wr_pulse,
    input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0] ro_regs,
    output logic [NUM_RO-1:0]               ro_rd_pulse
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'b00,
        WR_WAIT_W  = 2'b01,
        WR_WAIT_AW = 2'b10,
        WR_RESP    = 2'b11
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

    wr_state_e                  wr_state_q, wr_state_d;
    rd_state_e                  rd_state_q, rd_state_d;
    logic                       awready_q, awready_d, wready_q, wready_d;
    logic                       bvalid_q, bvalid_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic                       arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0]              rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic [IW-1:0]              awidx_q, awidx_d;
    logic [DW-1:0]              wdata_q, wdata_d;
    logic [SW-1:0]              wstrb_q, wstrb_d;
    logic [NUM_RW-1:0][DW-1:0]  rw_q, rw_d;
    logic [NUM_RW-1:0]          wr_pulse_q, wr_pulse_d;
    logic [NUM_RO-1:0][DW-1:0]  ro_snap_q;
    logic [NUM_RO-1:0]          rd_pulse_q, rd_pulse_d;

    logic          aw_hs_s, w_hs_s, ar_hs_s, wr_fire_s, wr_ok_s, rd_ok_s;
    logic [IW-1:0] wr_idx_s, rd_idx_s;
    logic [DW-1:0] wr_data_s, rd_mux_s;
    logic [SW-1:0] wr_strb_s;
    logic          unused_addr_s;

    // Byte offset bits never take part in decode.
    assign unused_addr_s = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs_s   = S_AXI_AWVALID & awready_q;
    assign w_hs_s    = S_AXI_WVALID & wready_q;
    assign ar_hs_s   = S_AXI_ARVALID & arready_q;
    // The write uses whichever half arrives now, otherwise the held half.
    assign wr_idx_s  = aw_hs_s ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : awidx_q;
    assign wr_data_s = w_hs_s ? S_AXI_WDATA : wdata_q;
    assign wr_strb_s = w_hs_s ? S_AXI_WSTRB : wstrb_q;
    assign wr_fire_s = (wr_state_q != WR_RESP) && (wr_state_d == WR_RESP);
    assign wr_ok_s   = int'(wr_idx_s) < NUM_RW;
    assign rd_idx_s  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_ok_s   = int'(rd_idx_s) < (NUM_RW + NUM_RO);

    // State, handshake and register storage; everything visible outside is a flop.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rw_q       <= '0;
            wr_pulse_q <= '0;
            ro_snap_q  <= '0;
            rd_pulse_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rw_q       <= rw_d;
            wr_pulse_q <= wr_pulse_d;
            ro_snap_q  <= ro_regs;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    // Write FSM next state: collect AW and W in either order, then hold the response.
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs_s && w_hs_s) wr_state_d = WR_RESP;
                else if (aw_hs_s)      wr_state_d = WR_WAIT_W;
                else if (w_hs_s)       wr_state_d = WR_WAIT_AW;
                else                   wr_state_d = WR_IDLE;
            end
            WR_WAIT_W:  wr_state_d = w_hs_s ? WR_RESP : WR_WAIT_W;
            WR_WAIT_AW: wr_state_d = aw_hs_s ? WR_RESP : WR_WAIT_AW;
            WR_RESP:    wr_state_d = S_AXI_BREADY ? WR_IDLE : WR_RESP;
            default:    wr_state_d = WR_IDLE;
        endcase
    end

    // Write FSM outputs: readies/valid follow the next state; response and held halves captured.
    always_comb begin
        awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_AW);
        wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_W);
        bvalid_d  = (wr_state_d == WR_RESP);
        awidx_d   = aw_hs_s ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : awidx_q;
        wdata_d   = w_hs_s ? S_AXI_WDATA : wdata_q;
        wstrb_d   = w_hs_s ? S_AXI_WSTRB : wstrb_q;
        if (wr_fire_s) bresp_d = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
        else           bresp_d = bresp_q;
    end

    // Byte-lane update of the addressed control word and its one-cycle write strobe.
    always_comb begin
        rw_d       = rw_q;
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (wr_fire_s && wr_ok_s && (wr_idx_s == IW'(i))) begin
                wr_pulse_d[i] = 1'b1;
                for (int b = 0; b < SW; b++) begin
                    if (wr_strb_s[b]) rw_d[i][8*b +: 8] = wr_data_s[8*b +: 8];
                    else              rw_d[i][8*b +: 8] = rw_q[i][8*b +: 8];
                end
            end else begin
                rw_d[i] = rw_q[i];
            end
        end
    end

    // Read FSM next state: one response slot, released by RREADY.
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: rd_state_d = ar_hs_s ? RD_RESP : RD_IDLE;
            RD_RESP: rd_state_d = S_AXI_RREADY ? RD_IDLE : RD_RESP;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Read data mux over pre-write control words and the status snapshot; unmapped reads give 0.
    always_comb begin
        rd_mux_s   = '0;
        rd_pulse_d = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            rd_mux_s = rd_mux_s | ({DW{rd_idx_s == IW'(i)}} & rw_q[i]);
        end
        for (int j = 0; j < NUM_RO; j++) begin
            rd_mux_s      = rd_mux_s | ({DW{rd_idx_s == IW'(NUM_RW + j)}} & ro_snap_q[j]);
            rd_pulse_d[j] = ar_hs_s && (rd_idx_s == IW'(NUM_RW + j));
        end
    end

    // Read FSM outputs: data and response registered at the AR handshake, then held.
    always_comb begin
        arready_d = (rd_state_d == RD_IDLE);
        rvalid_d  = (rd_state_d == RD_RESP);
        if (ar_hs_s) begin
            rdata_d = rd_mux_s;
            rresp_d = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else begin
            rdata_d = rdata_q;
            rresp_d = rresp_q;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign rw_regs       = rw_q;
    assign rw_wr_pulse   = wr_pulse_q;
    assign ro_rd_pulse   = rd_pulse_q;
endmodule

// File: tb/tb_axi_lite_cfg_regfile.sv
// tb_axi_lite_cfg_regfile: directed bench for the AXI4-Lite config register file.
`timescale 1ns/1ps
module tb_axi_lite_cfg_regfile;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [8:0]   awaddr, araddr;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] rw_regs, ro_regs;
    logic [7:0]   rw_wr_pulse, ro_rd_pulse;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [255:0] exp_rw = 256'd0;

    always #5 clk = ~clk;

    axi_lite_cfg_regfile #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(9), .NUM_RW(8), .NUM_RO(8)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .rw_regs(rw_regs), .rw_wr_pulse(rw_wr_pulse), .ro_regs(ro_regs), .ro_rd_pulse(ro_rd_pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        awaddr = 9'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0;
        bready = 1'b0; araddr = 9'd0; arvalid = 1'b0; rready = 1'b0;
    endtask

    // AW and W presented together; returns response, OR of write pulses, pulse-cycle count, latency.
    task automatic axi_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [7:0] pulse_or,
                             output int pulse_cycles, output int lat);
        logic aw_acc, w_acc, got;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        pulse_or = 8'd0; pulse_cycles = 0; lat = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            tick();
            lat++;
            if (aw_acc) awvalid = 1'b0;
            if (w_acc)  wvalid = 1'b0;
            pulse_or = pulse_or | rw_wr_pulse;
            if (rw_wr_pulse != 8'd0) pulse_cycles++;
            if (bvalid) got = 1'b1;
        end
        n_checks++;
        if (got !== 1'b1) begin
            n_fail++;
            $display("FAIL write_timeout addr=%h: bvalid=%b required 1", addr, bvalid);
        end
        resp = bresp;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick();
        pulse_or = pulse_or | rw_wr_pulse;
        if (rw_wr_pulse != 8'd0) pulse_cycles++;
        bready = 1'b0;
    endtask

    // Single AR; returns data, response, OR of read pulses, pulse-cycle count, latency.
    task automatic axi_read(input logic [8:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output logic [7:0] pulse_or, output int pulse_cycles, output int lat);
        logic ar_acc, got;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        pulse_or = 8'd0; pulse_cycles = 0; lat = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            ar_acc = arvalid && arready;
            tick();
            lat++;
            if (ar_acc) arvalid = 1'b0;
            pulse_or = pulse_or | ro_rd_pulse;
            if (ro_rd_pulse != 8'd0) pulse_cycles++;
            if (rvalid) got = 1'b1;
        end
        n_checks++;
        if (got !== 1'b1) begin
            n_fail++;
            $display("FAIL read_timeout addr=%h: rvalid=%b required 1", addr, rvalid);
        end
        data = rdata; resp = rresp;
        arvalid = 1'b0; rready = 1'b1;
        tick();
        pulse_or = pulse_or | ro_rd_pulse;
        if (ro_rd_pulse != 8'd0) pulse_cycles++;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ro_regs = 256'd0;
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: aw/w/ar/b/r=%b required 00000", {awready, wready, arready, bvalid, rvalid});
        end
        n_checks++;
        if (rw_regs !== 256'd0 || rw_wr_pulse !== 8'd0 || ro_rd_pulse !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_regs: rw_regs=%h pulses=%h/%h required 0", rw_regs, rw_wr_pulse, ro_rd_pulse);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++;
            $display("FAIL ready_after_release: aw/w/ar=%b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_read_after_reset();
        logic [31:0] d; logic [1:0] r; logic [7:0] p; int pc, lat;
        axi_read(9'h000, d, r, p, pc, lat);
        n_checks++;
        if (d !== 32'h0000_0000 || r !== 2'b00 || lat != 1) begin
            n_fail++;
            $display("FAIL t1_read0: data=%h resp=%b lat=%0d required 00000000/00/1", d, r, lat);
        end
    endtask

    task automatic test_write_strobe();
        logic [1:0] r; logic [7:0] p; int pc, lat; logic [31:0] d; logic [7:0] rp; int rpc, rlat;
        axi_write(9'h004, 32'h1234_5678, 4'b0101, r, p, pc, lat);
        exp_rw[63:32] = 32'h0034_0078;
        n_checks++;
        if (rw_regs[63:32] !== 32'h0034_0078 || r !== 2'b00 || p !== 8'h02 || pc != 1 || lat != 1) begin
            n_fail++;
            $display("FAIL t2_strobe: word1=%h resp=%b pulse=%h cycles=%0d lat=%0d required 00340078/00/02/1/1",
                     rw_regs[63:32], r, p, pc, lat);
        end
        axi_write(9'h004, 32'hFFFF_FFFF, 4'b0000, r, p, pc, lat);
        n_checks++;
        if (rw_regs !== exp_rw || r !== 2'b00 || p !== 8'h02 || pc != 1) begin
            n_fail++;
            $display("FAIL strb0_noop: word1=%h resp=%b pulse=%h cycles=%0d required 00340078/00/02/1",
                     rw_regs[63:32], r, p, pc);
        end
        axi_write(9'h007, 32'hAABB_CCDD, 4'b1010, r, p, pc, lat);
        exp_rw[63:32] = 32'hAA34_CC78;
        n_checks++;
        if (rw_regs !== exp_rw || p !== 8'h02) begin
            n_fail++;
            $display("FAIL strb_merge: word1=%h pulse=%h required aa34cc78/02", rw_regs[63:32], p);
        end
        axi_write(9'h01C, 32'hDEAD_BEEF, 4'b1111, r, p, pc, lat);
        exp_rw[255:224] = 32'hDEAD_BEEF;
        n_checks++;
        if (rw_regs !== exp_rw || r !== 2'b00 || p !== 8'h80) begin
            n_fail++;
            $display("FAIL last_rw_word: word7=%h resp=%b pulse=%h required deadbeef/00/80", rw_regs[255:224], r, p);
        end
        axi_read(9'h005, d, r, rp, rpc, rlat);
        n_checks++;
        if (d !== 32'hAA34_CC78 || r !== 2'b00 || rp !== 8'h00) begin
            n_fail++;
            $display("FAIL rw_readback: data=%h resp=%b ro_pulse=%h required aa34cc78/00/00", d, r, rp);
        end
    endtask

    task automatic test_aw_w_skew();
        wdata = 32'hCAFE_F00D; wstrb = 4'b1111; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        n_checks++;
        if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_w_held: awready=%b wready=%b bvalid=%b required 1/0/0", awready, wready, bvalid);
        end
        tick(); tick();
        awaddr = 9'h008; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        exp_rw[95:64] = 32'hCAFE_F00D;
        n_checks++;
        if (rw_regs !== exp_rw || rw_wr_pulse !== 8'h04 || bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_exec: word2=%h pulse=%h bvalid=%b aw/w=%b%b required cafef00d/04/1/00",
                     rw_regs[95:64], rw_wr_pulse, bvalid, awready, wready);
        end
        // A second write is offered while the response is stalled; it must wait.
        awaddr = 9'h00C; awvalid = 1'b1; wdata = 32'h1111_1111; wstrb = 4'b1111; wvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0 ||
                rw_wr_pulse !== 8'h00 || rw_regs !== exp_rw) begin
                n_fail++;
                $display("FAIL t3_hold%0d: bvalid=%b bresp=%b aw/w=%b%b pulse=%h word3=%h required 1/00/00/00/00000000",
                         k, bvalid, bresp, awready, wready, rw_wr_pulse, rw_regs[127:96]);
            end
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_release: bvalid=%b aw/w=%b%b required 0/11", bvalid, awready, wready);
        end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        exp_rw[127:96] = 32'h1111_1111;
        n_checks++;
        if (bvalid !== 1'b1 || rw_regs !== exp_rw || rw_wr_pulse !== 8'h08) begin
            n_fail++;
            $display("FAIL back_to_back: bvalid=%b word3=%h pulse=%h required 1/11111111/08", bvalid, rw_regs[127:96], rw_wr_pulse);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic test_status_read();
        logic [31:0] d; logic [1:0] r; logic [7:0] p; int pc, lat;
        ro_regs[31:0] = 32'h0000_0ABC;
        ro_regs[63:32] = 32'h0000_0111;
        ro_regs[255:224] = 32'h5A5A_0001;
        tick(); tick();
        axi_read(9'h020, d, r, p, pc, lat);
        n_checks++;
        if (d !== 32'h0000_0ABC || r !== 2'b00 || p !== 8'h01 || pc != 1) begin
            n_fail++;
            $display("FAIL t4_ro0: data=%h resp=%b pulse=%h cycles=%0d required 00000abc/00/01/1", d, r, p, pc);
        end
        axi_read(9'h03C, d, r, p, pc, lat);
        n_checks++;
        if (d !== 32'h5A5A_0001 || r !== 2'b00 || p !== 8'h80 || pc != 1) begin
            n_fail++;
            $display("FAIL last_ro_word: data=%h resp=%b pulse=%h cycles=%0d required 5a5a0001/00/80/1", d, r, p, pc);
        end
        // Input changes in the AR cycle itself are too late for the snapshot.
        ro_regs[63:32] = 32'h0000_0222;
        axi_read(9'h024, d, r, p, pc, lat);
        n_checks++;
        if (d !== 32'h0000_0111 || p !== 8'h02) begin
            n_fail++;
            $display("FAIL snapshot_age: data=%h pulse=%h required 00000111/02", d, p);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] r; logic [7:0] p; int pc, lat; logic [31:0] d;
        axi_write(9'h020, 32'hFFFF_FFFF, 4'b1111, r, p, pc, lat);
        n_checks++;
        if (r !== 2'b10 || p !== 8'h00 || rw_regs !== exp_rw) begin
            n_fail++;
            $display("FAIL t5_wr_ro: resp=%b pulse=%h required 10/00, rw_regs changed=%b", r, p, rw_regs !== exp_rw);
        end
        axi_write(9'h1FC, 32'hFFFF_FFFF, 4'b1111, r, p, pc, lat);
        n_checks++;
        if (r !== 2'b10 || p !== 8'h00 || rw_regs !== exp_rw) begin
            n_fail++;
            $display("FAIL t5_wr_oor: resp=%b pulse=%h required 10/00, rw_regs changed=%b", r, p, rw_regs !== exp_rw);
        end
        axi_read(9'h1FC, d, r, p, pc, lat);
        n_checks++;
        if (d !== 32'd0 || r !== 2'b10 || p !== 8'h00) begin
            n_fail++;
            $display("FAIL t5_rd_oor: data=%h resp=%b pulse=%h required 00000000/10/00", d, r, p);
        end
        axi_read(9'h040, d, r, p, pc, lat);
        n_checks++;
        if (d !== 32'd0 || r !== 2'b10 || p !== 8'h00) begin
            n_fail++;
            $display("FAIL rd_first_oor: data=%h resp=%b pulse=%h required 00000000/10/00", d, r, p);
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0] r; logic [7:0] p; int pc, lat;
        axi_write(9'h010, 32'h0000_1234, 4'b1111, r, p, pc, lat);
        exp_rw[159:128] = 32'h0000_1234;
        awaddr = 9'h010; awvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'b1111; wvalid = 1'b1;
        araddr = 9'h010; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        exp_rw[159:128] = 32'h5555_5555;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h0000_1234 || bvalid !== 1'b1 || rw_regs !== exp_rw) begin
            n_fail++;
            $display("FAIL same_cycle_rw: rvalid=%b rdata=%h bvalid=%b word4=%h required 1/00001234/1/55555555",
                     rvalid, rdata, bvalid, rw_regs[159:128]);
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [1:0] r; logic [7:0] p; int pc, lat;
        awaddr = 9'h018; awvalid = 1'b1; wdata = 32'h0000_0077; wstrb = 4'b1111; wvalid = 1'b1;
        araddr = 9'h000; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        n_checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1 || rw_regs[223:192] !== 32'h0000_0077) begin
            n_fail++;
            $display("FAIL t6_pre: bvalid=%b rvalid=%b word6=%h required 1/1/00000077", bvalid, rvalid, rw_regs[223:192]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || rw_regs !== 256'd0 || awready !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_async_reset: bvalid=%b rvalid=%b awready=%b rw_nonzero=%b required 0/0/0/0",
                     bvalid, rvalid, awready, rw_regs !== 256'd0);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        exp_rw = 256'd0;
        axi_write(9'h000, 32'h0000_BEEF, 4'b1111, r, p, pc, lat);
        exp_rw[31:0] = 32'h0000_BEEF;
        n_checks++;
        if (r !== 2'b00 || p !== 8'h01 || rw_regs !== exp_rw) begin
            n_fail++;
            $display("FAIL t6_clean_write: resp=%b pulse=%h word0=%h required 00/01/0000beef", r, p, rw_regs[31:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_strobe();
        test_aw_w_skew();
        test_status_read();
        test_slverr();
        test_same_cycle();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
